instr_fetch: RTL and testbench

Instruction fetch stage directly upstream of the decode/control unit. It owns the program counter and issues word-aligned requests to instruction memory over a request/grant/response handshake. It buffers returned instructions in a small in-order queue and presents `{instr, instr_pc}` to decode with a valid/ready handshake. Taken-branch redirects flush the stage: fetch restarts at the target and stale in-flight responses are discarded.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/instr_fetch.sv | 140 ++++++++++++++
 tb/tb_instr_fetch.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    // One queue entry: the fetch address and the instruction word returned for it.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        RESET,
        RUN,
        DRAIN
    } fetch_state_e;

    localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & INSTR_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush, flop-held head and occupancy count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [AW:0]  count_o
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL) || do_pop);

    // Pointer and occupancy next-state; flush empties the queue and wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage and pointer registers; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues imem requests, buffers responses
// in order and hands {instr, instr_pc} to decode. Redirects flush the stage and
// discard in-flight responses. Optional stall counter under INSTR_FETCH_PERF_EN.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(BUF_DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] pend_cnt_q, pend_cnt_d;
    logic [CW-1:0] disc_cnt_q, disc_cnt_d;
    logic [CW-1:0] buf_count, tag_count;
    fetch_entry_t  buf_head, tag_head, buf_push_data, tag_push_data;
    logic          grant, discard, buf_push, dec_pop;

    // Space check counts granted-but-unanswered requests so a response always has a slot.
    assign imem_req  = (state_q != RESET)
                     && (({1'b0, buf_count} + {1'b0, pend_cnt_q}) < DEPTH_L)
                     && !redirect;
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req && imem_gnt;

    // Stale responses: those still owed from before a redirect, or arriving in the redirect cycle.
    assign discard  = imem_rvalid && (redirect || (disc_cnt_q != '0));
    assign buf_push = imem_rvalid && !discard;
    assign dec_pop  = instr_valid && instr_ready;

    assign tag_push_data = '{pc: fetch_pc_q, instr: '0};
    assign buf_push_data = '{pc: tag_head.pc, instr: imem_rdata};

    // PC tags of live requests; the tags of requests made stale by a redirect are dropped with it.
    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_tag_q (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (redirect),
        .push_i     (grant),
        .push_data_i(tag_push_data),
        .pop_i      (buf_push),
        .head_o     (tag_head),
        .count_o    (tag_count)
    );

    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_instr_q (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (redirect),
        .push_i     (buf_push),
        .push_data_i(buf_push_data),
        .pop_i      (dec_pop),
        .head_o     (buf_head),
        .count_o    (buf_count)
    );

    assign instr_valid = (buf_count != '0);
    assign instr       = buf_head.instr;
    assign instr_pc    = buf_head.pc;

    // Next PC, outstanding/discard bookkeeping and FSM transitions.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        disc_cnt_d = disc_cnt_q;
        state_d    = state_q;
        pend_cnt_d = pend_cnt_q + CW'(grant) - CW'(imem_rvalid);
        if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
        if (redirect) begin
            fetch_pc_d = align_pc(redirect_pc);
            disc_cnt_d = pend_cnt_q - CW'(imem_rvalid);
        end else if (imem_rvalid && (disc_cnt_q != '0)) begin
            disc_cnt_d = disc_cnt_q - CW'(1);
        end
        case (state_q)
            RESET:   state_d = RUN;
            RUN:     if (redirect && (disc_cnt_d != '0)) state_d = DRAIN;
            DRAIN:   if (disc_cnt_d == '0) state_d = RUN;
            default: state_d = RESET;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RESET;
            fetch_pc_q <= align_pc(RESET_PC);
            pend_cnt_q <= '0;
            disc_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_cnt_q <= pend_cnt_d;
            disc_cnt_q <= disc_cnt_d;
        end
    end

`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] stall_q, stall_d;

    // Saturating count of cycles where decode is ready but has nothing to take.
    always_comb begin
        stall_d = stall_q;
        if (instr_ready && !instr_valid && (state_q != RESET) && (stall_q != '1))
            stall_d = stall_q + 32'd1;
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

    logic unused_tag;
    assign unused_tag = ^{tag_head.instr, tag_count, redirect_pc[1:0]};

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: behavioural memory, expected program-order
// stream model, and a decoupled monitor comparing each decode handshake.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] MAGIC  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_gnt, imem_rvalid, redirect;
    logic [31:0] imem_addr, imem_rdata, redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] stall_cycles;
`endif

    instr_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
`ifdef INSTR_FETCH_PERF_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Expected delivery stream: program order from the last restart point.
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;

    // Memory model: in-order responses, random latency in [lat_min, lat_max].
    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mreq_t;
    mreq_t       mq[$];
    int unsigned cyc = 0;
    int unsigned last_due = 0;
    int unsigned lat_min = 1, lat_max = 1;
    int          grants = 0, hs = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
                last_due = 0;
            end else if (imem_req && imem_gnt) begin
                int unsigned due;
                due = cyc + $urandom_range(lat_max, lat_min);
                if (due < last_due) due = last_due;
                last_due = due;
                mq.push_back(mreq_t'{addr: imem_addr, due: due});
                grants++;
            end
        end
    end

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst_n && (mq.size() != 0) && (mq[0].due <= cyc)) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mq[0].addr ^ MAGIC;
                void'(mq.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
        end
    end

    // Monitor: protocol properties plus scoreboard compare on every handshake.
    logic        p_req, p_gnt, p_valid, p_ready, p_redir;
    logic [31:0] p_addr, p_instr, p_pc, p_target;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_req = 0; p_gnt = 0; p_valid = 0; p_ready = 0; p_redir = 0;
                p_addr = '0; p_instr = '0; p_pc = '0; p_target = '0;
            end else begin
                if (redirect) chk_eq("req_low_on_redirect", 32'(imem_req), 32'd0);
                if (imem_req) chk_eq("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
                if (p_req && !p_gnt) begin
                    chk_eq("addr_hold", imem_addr, p_addr);
                    if (!redirect) chk_eq("req_hold", 32'(imem_req), 32'd1);
                end
                if (p_redir) begin
                    chk_eq("valid_after_redirect", 32'(instr_valid), 32'd0);
                    if (imem_req) chk_eq("addr_after_redirect", imem_addr, p_target);
                end
                if (p_valid && !p_ready && !p_redir) begin
                    chk_eq("valid_hold", 32'(instr_valid), 32'd1);
                    chk_eq("instr_hold", instr, p_instr);
                    chk_eq("pc_hold", instr_pc, p_pc);
                end
                if (instr_valid && instr_ready) begin
                    hs++;
                    if (exp_q.size() == 0) begin
                        chk_eq("scoreboard_empty", instr_pc, 32'hXXXX_XXXX);
                    end else begin
                        logic [31:0] e;
                        e = exp_q.pop_front();
                        chk_eq("sb_pc", instr_pc, e);
                        chk_eq("sb_instr", instr, e ^ MAGIC);
                    end
                end
                p_req = imem_req; p_gnt = imem_gnt; p_addr = imem_addr;
                p_valid = instr_valid; p_ready = instr_ready;
                p_instr = instr; p_pc = instr_pc;
                p_redir = redirect; p_target = {redirect_pc[31:2], 2'b00};
            end
        end
    end

    // One cycle of stimulus; a redirect seen last cycle restarts the expected stream.
    task automatic drive(input bit g, input bit rdy, input bit rd, input logic [31:0] rpc);
        @(posedge clk);
        if (redirect) begin
            exp_q.delete();
            model_pc = {redirect_pc[31:2], 2'b00};
        end
        while (exp_q.size() < 16) begin
            exp_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
        end
        #1;
        imem_gnt = g; instr_ready = rdy; redirect = rd; redirect_pc = rpc;
    endtask

    task automatic check_reset_vals();
        chk_eq("rst_req", 32'(imem_req), 32'd0);
        chk_eq("rst_addr", imem_addr, RST_PC);
        chk_eq("rst_valid", 32'(instr_valid), 32'd0);
        chk_eq("rst_instr", instr, 32'd0);
        chk_eq("rst_pc", instr_pc, 32'd0);
`ifdef INSTR_FETCH_PERF_EN
        chk_eq("rst_stall", stall_cycles, 32'd0);
`endif
    endtask

    task automatic release_reset(input bit g);
        @(posedge clk);
        #1;
        rst_n = 1'b1; imem_gnt = g; instr_ready = 1'b1; redirect = 1'b0;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            drive(1, 1, 0, '0);
            @(negedge clk);
            seen = instr_valid;
        end
        chk_eq({name, "_timeout"}, 32'(seen), 32'd1);
        if (seen) begin
            chk_eq({name, "_pc"}, instr_pc, exp_pc);
            chk_eq({name, "_instr"}, instr, exp_pc ^ MAGIC);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; imem_gnt = 0; instr_ready = 0; redirect = 0; redirect_pc = '0;
        model_pc = RST_PC;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals();

        // Reset release and streaming with 1-cycle memory.
        release_reset(1);
        @(negedge clk);
        chk_eq("c0_req", 32'(imem_req), 32'd0);
        drive(1, 1, 0, '0); @(negedge clk);
        chk_eq("c1_req", 32'(imem_req), 32'd1);
        chk_eq("c1_addr", imem_addr, RST_PC);
        drive(1, 1, 0, '0); @(negedge clk);
        chk_eq("c2_valid", 32'(instr_valid), 32'd0);
        drive(1, 1, 0, '0); @(negedge clk);
        chk_eq("c3_valid", 32'(instr_valid), 32'd1);
        chk_eq("c3_pc", instr_pc, RST_PC);
        chk_eq("c3_instr", instr, RST_PC ^ MAGIC);
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, '0); @(negedge clk);
            chk_eq("stream_valid", 32'(instr_valid), 32'd1);
        end

        // Back-pressure: decode stalls, buffering fills to depth.
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, '0); @(negedge clk);
        end
        chk_eq("inflight_plus_buffered", 32'(grants - hs), 32'd4);
        chk_eq("req_dropped_full", 32'(imem_req), 32'd0);
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, '0); @(negedge clk);
            chk_eq("release_no_gap", 32'(instr_valid), 32'd1);
        end

        // 3-cycle memory, redirect with two requests in flight.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 30; i++) begin
            if (mq.size() == 0 && !instr_valid) break;
            drive(0, 1, 0, '0); @(negedge clk);
        end
        chk_eq("drain_timeout", 32'(mq.size()), 32'd0);
        drive(1, 1, 0, '0); @(negedge clk);
        drive(1, 1, 0, '0); @(negedge clk);
        drive(0, 1, 1, 32'h0000_0100); @(negedge clk);
        wait_valid("redir_100", 32'h0000_0100);

        // Unaligned redirect target.
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, '0); @(negedge clk);
        end
        drive(1, 1, 1, 32'h0000_0203); @(negedge clk);
        drive(1, 1, 0, '0); @(negedge clk);
        chk_eq("redir_203_req", 32'(imem_req), 32'd1);
        chk_eq("redir_203_addr", imem_addr, 32'h0000_0200);
        wait_valid("redir_203", 32'h0000_0200);

        // Redirect coinciding with a response and a decode handshake.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, '0); @(negedge clk);
        end
        drive(1, 1, 1, 32'h0000_0400); @(negedge clk);
        if (imem_rvalid) chk_eq("hs_in_redirect_cycle", 32'(instr_valid), 32'd1);
        drive(1, 1, 0, '0); @(negedge clk);
        chk_eq("flush_empty", 32'(instr_valid), 32'd0);
        wait_valid("redir_400", 32'h0000_0400);

        // Randomised traffic with variable latency, near-wrap targets included.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 800; i++) begin
            bit g, rdy, rd;
            logic [31:0] rpc;
            g   = ($urandom % 10) < 7;
            rdy = ($urandom % 10) < 7;
            rd  = ($urandom % 32) == 0;
            rpc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            drive(g, rdy, rd, rpc);
            @(negedge clk);
        end

        // Reset asserted mid-traffic, then grants withheld after release.
        lat_min = 1; lat_max = 1;
        drive(1, 1, 0, '0);
        #2;
        rst_n = 1'b0;
        imem_gnt = 0; redirect = 0; redirect_pc = '0;
        exp_q.delete(); model_pc = RST_PC; grants = 0; hs = 0;
        @(negedge clk);
        check_reset_vals();
        release_reset(0);
        @(negedge clk);
        chk_eq("r2_c0_req", 32'(imem_req), 32'd0);
        for (int c = 1; c <= 5; c++) begin
            drive(0, 1, 0, '0); @(negedge clk);
        end
        chk_eq("r2_addr_held", imem_addr, RST_PC);
        for (int c = 6; c <= 10; c++) begin
            drive(1, 1, 0, '0); @(negedge clk);
            if (c == 7) chk_eq("r2_c7_valid", 32'(instr_valid), 32'd0);
            if (c == 8) begin
                chk_eq("r2_c8_valid", 32'(instr_valid), 32'd1);
                chk_eq("r2_c8_pc", instr_pc, RST_PC);
            end
`ifdef INSTR_FETCH_PERF_EN
            if (c == 10) chk_eq("stall_cycles", stall_cycles, 32'd7);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
